down_timer: RTL
===============

Name: down_timer

Overview:
- Programmable down-counting timer: the complement of the team's free-running up counter.
- Loads a start value, counts down to zero at a prescaled tick rate, and flags terminal count.
- Supports one-shot and auto-reload (periodic) modes.
- Used as the timeout/period generator alongside the existing counters in the same clock domain.

Parameters:
- WIDTH, 4, width of the count and load value.
- PRESCALE_W, 4, width of the prescale divisor input.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- load  input  1  single-cycle pulse; capture load_value.
- load_value  input  WIDTH  reload/start value.
- start  input  1  single-cycle pulse; begin or resume counting.
- stop  input  1  single-cycle pulse; pause counting.
- auto_reload  input  1  1 = periodic mode, 0 = one-shot; sampled at the terminal-count edge.
- prescale  input  PRESCALE_W  tick divisor minus one; 0 = tick every cycle.
- count  output  WIDTH  current count (registered).
- busy  output  1  high while state is RUN.
- tc_pulse  output  1  one-cycle registered pulse on reaching terminal count.
- expired  output  1  sticky one-shot completion flag.

Behaviour:
- Reset (reset low, asynchronous):
  - count=0, reload_reg=0, pre_cnt=0, state=IDLE.
  - tc_pulse=0, expired=0; busy=0.
- States:
  - IDLE: stopped or paused.
  - RUN: counting.
  - DONE: one-shot finished.
  - busy is decoded from the state register only: busy = (state==RUN).
- Priority at any edge: load > stop > start > tick.
- load, in any state:
  - reload_reg<=load_value, count<=load_value, pre_cnt<=0.
  - state<=IDLE, expired<=0, tc_pulse<=0.
- start, in IDLE or DONE:
  - If count==0, count<=reload_reg.
  - If the effective value (count if nonzero, else reload_reg) is 0, start is ignored and the state is unchanged.
  - Otherwise state<=RUN, expired<=0, pre_cnt<=0.
  - start in RUN has no effect.
- stop, in RUN:
  - state<=IDLE; count and pre_cnt hold.
  - A later start resumes from the held count.
  - stop in IDLE or DONE has no effect.
  - If stop and start arrive in the same cycle, stop wins.
- Prescaler, active only in RUN:
  - tick = (pre_cnt >= prescale).
  - On tick, pre_cnt<=0; otherwise pre_cnt<=pre_cnt+1.
  - The >= compare makes a mid-run reduction of prescale take effect without a full wrap.
- On tick in RUN with count>1: count<=count-1.
- On tick in RUN with count==1:
  - tc_pulse<=1 for exactly one cycle.
  - If auto_reload=1: count<=reload_reg, stay in RUN.
  - If auto_reload=0: count<=0, state<=DONE, expired<=1.
- Latency with prescale=0 and start at edge k:
  - First decrement at edge k+1.
  - tc_pulse goes high after edge k+N for N=loaded value, and stays high for one cycle.
  - Auto-reload period is N*(prescale+1) cycles between tc_pulses.
- Held state:
  - tc_pulse is 0 at every edge that is not a terminal count.
  - expired holds until load or an accepted start.
- Arithmetic:
  - The decrement never underflows; count==0 is never decremented.
  - No wrap from 0 to all-ones.
- Reset mid-RUN aborts immediately: all outputs return to reset values and the remaining count is discarded.
- load during RUN aborts the run and reloads; a tc_pulse due on that same edge is suppressed.

Decomposition:
- Shared package down_timer_pkg:
  - State typedef: enum IDLE/RUN/DONE, 2-bit encoding.
  - Constants: default WIDTH and PRESCALE_W.
- One sub-module, tick_prescaler:
  - Holds pre_cnt and the compare.
  - Inputs: clk, reset, enable, clear, prescale.
  - Output: tick.
- down_timer holds the FSM, count and reload_reg.

Test Plan:
- Reset: drive reset low mid-run with count=5 -> count=0, busy=0, tc_pulse=0, expired=0 immediately, without waiting for clk.
- One-shot: load 3, prescale=0, auto_reload=0, start -> count 3,2,1,0 on successive edges; tc_pulse high one cycle with count=0; state DONE, expired=1, busy=0; count stays 0 for 10 further cycles.
- Auto-reload: load 4, prescale=0, auto_reload=1, start -> tc_pulse every 4 cycles for 3 periods; count sequence 4,3,2,1,4,3,2,1...; busy stays 1; expired stays 0.
- Prescale: load 2, prescale=2, start -> count decrements every 3 cycles; tc_pulse 6 cycles after start.
- Pause/resume: load 6, start, stop after 2 decrements -> count holds 4 for 5 cycles with busy=0. Then start -> resumes 3,2,1,0. Separately, same-cycle stop+start while in RUN -> state IDLE.
- Edge cases:
  - load 0 then start -> ignored, busy stays 0.
  - load 5 asserted on the same edge as a terminal tick -> count=5, tc_pulse=0, state IDLE.
  - start in DONE after load 2 -> reruns 2,1,0 and clears expired.

Source files
------------

// File: rtl/down_timer_pkg.sv
// Shared types and default sizes for the down-counting timer.
package down_timer_pkg;

   localparam int DEF_WIDTH      = 4;
   localparam int DEF_PRESCALE_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/tick_prescaler.sv
// Divides the clock into count ticks; tick fires when pre_cnt reaches prescale.
module tick_prescaler
   import down_timer_pkg::*;
#(
   parameter int PRESCALE_W = DEF_PRESCALE_W
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  enable,
   input  logic                  clear,
   input  logic [PRESCALE_W-1:0] prescale,
   output logic                  tick
);

   logic [PRESCALE_W-1:0] pre_cnt;

   // >= rather than == so lowering prescale mid-run never forces a full wrap.
   assign tick = enable && (pre_cnt >= prescale);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pre_cnt <= '0;
      end else if (clear) begin
         pre_cnt <= '0;
      end else if (enable) begin
         if (tick) pre_cnt <= '0;
         else      pre_cnt <= pre_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/down_timer.sv
// Programmable down timer with one-shot and auto-reload modes.
module down_timer
   import down_timer_pkg::*;
#(
   parameter int WIDTH      = DEF_WIDTH,
   parameter int PRESCALE_W = DEF_PRESCALE_W
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  load,
   input  logic [WIDTH-1:0]      load_value,
   input  logic                  start,
   input  logic                  stop,
   input  logic                  auto_reload,
   input  logic [PRESCALE_W-1:0] prescale,
   output logic [WIDTH-1:0]      count,
   output logic                  busy,
   output logic                  tc_pulse,
   output logic                  expired
);

   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   state_t           state;
   logic [WIDTH-1:0] reload_reg;
   logic [WIDTH-1:0] eff_value;
   logic             running;
   logic             stop_hit;
   logic             start_ok;
   logic             pre_en;
   logic             pre_clr;
   logic             tick;

   assign running   = (state == RUN);
   assign busy      = running;
   assign eff_value = (count != '0) ? count : reload_reg;
   assign stop_hit  = stop && running;
   assign start_ok  = start && !running && (eff_value != '0);

   // The prescaler only advances on edges where nothing of higher priority acts.
   assign pre_en  = running && !load && !stop_hit;
   assign pre_clr = load || start_ok;

   tick_prescaler #(
      .PRESCALE_W(PRESCALE_W)
   ) u_prescaler (
      .clk     (clk),
      .reset   (reset),
      .enable  (pre_en),
      .clear   (pre_clr),
      .prescale(prescale),
      .tick    (tick)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         count      <= '0;
         reload_reg <= '0;
         tc_pulse   <= 1'b0;
         expired    <= 1'b0;
      end else if (load) begin
         reload_reg <= load_value;
         count      <= load_value;
         state      <= IDLE;
         expired    <= 1'b0;
         tc_pulse   <= 1'b0;
      end else begin
         tc_pulse <= 1'b0;
         if (stop_hit) begin
            state <= IDLE;
         end else if (start && !running) begin
            if (count == '0) count <= reload_reg;
            if (start_ok) begin
               state   <= RUN;
               expired <= 1'b0;
            end
         end else if (running && tick) begin
            if (count > ONE) begin
               count <= count - ONE;
            end else if (count == ONE) begin
               tc_pulse <= 1'b1;
               if (auto_reload) begin
                  count <= reload_reg;
               end else begin
                  count   <= '0;
                  state   <= DONE;
                  expired <= 1'b1;
               end
            end
         end
      end
   end

endmodule
